complex_div_coef_real: RTL and testbench

- Inverse of the real-coefficient complex multiplier: divides a complex sample (cr + j·ci) by a pure-real coefficient br, returning (ar + j·ai).
- Sits downstream of complex-by-real scaling stages to undo gain or coefficient normalisation.
- Sequential restoring divider: both lanes are computed in parallel, one quotient bit per cycle.
- Valid/ready handshakes on both input and output.

---
 rtl/complex_div_pkg.sv | 48 ++++
 rtl/complex_div_coef_real_lane.sv | 50 +++++
 rtl/complex_div_coef_real.sv | 145 ++++++++++++++
 tb/tb_complex_div_coef_real.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/complex_div_pkg.sv
// Shared types and helpers for the complex-by-real restoring divider.
package complex_div_pkg;

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Default word lengths
  localparam int WL_DEF    = 14;
  localparam int WL_IN_DEF = 28;
  localparam int CNT_W_DEF = 5;

  // Width of the magnitude carried through sat_signed; callers zero-extend into it.
  localparam int SAT_W = 64;

  // Applies a sign to an unsigned magnitude and clamps it to a wl-bit signed range.
  // Result packs {overflow, value}; the low wl bits of value hold the clamped word.
  function automatic logic [SAT_W:0] sat_signed(input logic [SAT_W-1:0] mag,
                                                input logic             neg,
                                                input int               wl);
    logic [SAT_W-1:0] lim;
    logic [SAT_W-1:0] val;
    logic             ovf;
    lim = 64'd1 << (wl - 1);
    ovf = 1'b0;
    if (neg) begin
      if (mag > lim) begin
        val = -lim;
        ovf = 1'b1;
      end else begin
        val = -mag;
      end
    end else begin
      if (mag >= lim) begin
        val = lim - 64'd1;
        ovf = 1'b1;
      end else begin
        val = mag;
      end
    end
    return {ovf, val};
  endfunction

endpackage

// File: rtl/complex_div_coef_real_lane.sv
// One unsigned restoring divider lane: a numerator bit per step, MSB first.
module div_lane_uns #(
  parameter int WL_in = 28,
  parameter int WL    = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WL_in-1:0] num,
  input  logic [WL-1:0]    den,
  output logic [WL_in-1:0] quo
);

  logic [WL_in-1:0] num_reg;
  logic [WL_in-1:0] quo_reg;
  logic [WL-1:0]    den_reg;
  logic [WL-1:0]    rem_reg;
  logic [WL:0]      shifted;
  logic             q_bit;

  // Partial remainder with the next numerator bit appended, and the trial compare.
  // For a non-zero divisor the remainder stays below den, so WL bits hold it.
  always_comb begin
    shifted = {rem_reg, num_reg[WL_in-1]};
    q_bit   = (shifted >= {1'b0, den_reg});
  end

  // Load operands, then one restoring subtract per step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_reg <= '0;
      quo_reg <= '0;
      den_reg <= '0;
      rem_reg <= '0;
    end else if (load) begin
      num_reg <= num;
      den_reg <= den;
      quo_reg <= '0;
      rem_reg <= '0;
    end else if (step) begin
      num_reg <= {num_reg[WL_in-2:0], 1'b0};
      quo_reg <= {quo_reg[WL_in-2:0], q_bit};
      rem_reg <= WL'(q_bit ? (shifted - {1'b0, den_reg}) : shifted);
    end
  end

  assign quo = quo_reg;

endmodule

// File: rtl/complex_div_coef_real.sv
// Complex sample divided by a real coefficient: two parallel restoring lanes,
// sign/saturation applied at the end, valid/ready on both sides.
module complex_div_coef_real
  import complex_div_pkg::*;
#(
  parameter int WL    = WL_DEF,
  parameter int WL_in = WL_IN_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WL_in-1:0] cr,
  input  logic [WL_in-1:0] ci,
  input  logic [WL-1:0]    br,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WL-1:0]    ar,
  output logic [WL-1:0]    ai,
  output logic             sat,
  output logic             div_zero
);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic             sgn_r_reg, sgn_i_reg;    // result signs
  logic             neg_r_reg, neg_i_reg;    // numerator signs, used when br = 0
  logic             zero_r_reg, zero_i_reg;  // numerator is zero, used when br = 0
  logic             dz_reg;

  logic [WL_in-1:0] cr_mag, ci_mag, quo_r, quo_i;
  logic [WL-1:0]    br_mag;
  logic             accept, step;

  logic [WL-1:0]    ar_next, ai_next;
  logic             ovf_r, ovf_i, sat_next;

  // |x| of the most negative value wraps to 2^(n-1), which is exact as unsigned.
  assign cr_mag = cr[WL_in-1] ? (-cr) : cr;
  assign ci_mag = ci[WL_in-1] ? (-ci) : ci;
  assign br_mag = br[WL-1]    ? (-br) : br;

  assign accept    = (state_reg == IDLE) && in_valid;
  assign step      = (state_reg == CALC);
  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);

  div_lane_uns #(.WL_in(WL_in), .WL(WL)) lane_r (
    .clk (clk), .rst (rst), .load (accept), .step (step),
    .num (cr_mag), .den (br_mag), .quo (quo_r)
  );

  div_lane_uns #(.WL_in(WL_in), .WL(WL)) lane_i (
    .clk (clk), .rst (rst), .load (accept), .step (step),
    .num (ci_mag), .den (br_mag), .quo (quo_i)
  );

  // State and iteration counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic: WL_in CALC cycles, one FIN cycle, hold in DONE until taken.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          state_next = CALC;
          cnt_next   = '0;
        end
      end
      CALC: begin
        if (cnt_reg == CNT_W'(WL_in - 1)) begin
          state_next = FIN;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      FIN:     state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Capture sign and zero information at the input handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sgn_r_reg  <= 1'b0;
      sgn_i_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      neg_i_reg  <= 1'b0;
      zero_r_reg <= 1'b0;
      zero_i_reg <= 1'b0;
      dz_reg     <= 1'b0;
    end else if (accept) begin
      sgn_r_reg  <= cr[WL_in-1] ^ br[WL-1];
      sgn_i_reg  <= ci[WL_in-1] ^ br[WL-1];
      neg_r_reg  <= cr[WL_in-1];
      neg_i_reg  <= ci[WL_in-1];
      zero_r_reg <= (cr == '0);
      zero_i_reg <= (ci == '0);
      dz_reg     <= (br == '0);
    end
  end

  // Signed, saturated results; a zero divisor forces the rails (or 0 for a 0 numerator).
  always_comb begin
    ar_next  = WL'(sat_signed(SAT_W'(quo_r), sgn_r_reg, WL));
    ai_next  = WL'(sat_signed(SAT_W'(quo_i), sgn_i_reg, WL));
    ovf_r    = 1'(sat_signed(SAT_W'(quo_r), sgn_r_reg, WL) >> SAT_W);
    ovf_i    = 1'(sat_signed(SAT_W'(quo_i), sgn_i_reg, WL) >> SAT_W);
    sat_next = ovf_r | ovf_i;
    if (dz_reg) begin
      ar_next  = zero_r_reg ? '0 : (neg_r_reg ? {1'b1, {(WL-1){1'b0}}} : {1'b0, {(WL-1){1'b1}}});
      ai_next  = zero_i_reg ? '0 : (neg_i_reg ? {1'b1, {(WL-1){1'b0}}} : {1'b0, {(WL-1){1'b1}}});
      sat_next = 1'b1;
    end
  end

  // Result registers, written only in FIN and held through DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ar       <= '0;
      ai       <= '0;
      sat      <= 1'b0;
      div_zero <= 1'b0;
    end else if (state_reg == FIN) begin
      ar       <= ar_next;
      ai       <= ai_next;
      sat      <= sat_next;
      div_zero <= dz_reg;
    end
  end

endmodule

// File: tb/tb_complex_div_coef_real.sv
// Directed, table-driven bench for complex_div_coef_real.
module tb_complex_div_coef_real;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [27:0] cr;
  logic signed [27:0] ci;
  logic signed [13:0] br;
  logic               out_valid;
  logic               out_ready;
  logic signed [13:0] ar;
  logic signed [13:0] ai;
  logic               sat;
  logic               div_zero;

  int tests_run = 0;
  int tests_failed = 0;

  complex_div_coef_real dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cr        (cr),
    .ci        (ci),
    .br        (br),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ar        (ar),
    .ai        (ai),
    .sat       (sat),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic signed [27:0] cr;
    logic signed [27:0] ci;
    logic signed [13:0] br;
    int                 ar;
    int                 ai;
    logic               sat;
    logic               dz;
    logic               chk_sat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input longint act, input longint exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Present operands for one edge; caller is at 1ns after a rising edge.
  task automatic start_op(input logic signed [27:0] c_r, input logic signed [27:0] c_i,
                          input logic signed [13:0] b);
    cr = c_r;
    ci = c_i;
    br = b;
    in_valid = 1'b1;
    check("in_ready_before_accept", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Count edges from the accepting edge until out_valid, watching in_ready stay low.
  task automatic wait_done(output int lat, output int ready_hi);
    lat = 0;
    ready_hi = 0;
    while (!out_valid && lat < 100) begin
      if (in_ready) ready_hi++;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  // Take the result and confirm the return to IDLE.
  task automatic pop_result();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("out_valid_after_pop", out_valid, 0);
    check("in_ready_after_pop", in_ready, 1);
  endtask

  initial begin
    int lat;
    int ready_hi;
    int seen_valid;

    vecs[0] = '{28'sd100, -28'sd200, 14'sd10, 10, -20, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{28'sd7, -28'sd7, 14'sd2, 3, -3, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{-28'sd1, 28'sd1, 14'sd4, 0, 0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{-28'sd24576, 28'sd0, -14'sd3, 8191, 0, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{28'sd1048576, -28'sd1048576, 14'sd1, 8191, -8192, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{-28'sd134217728, 28'sd134217727, -14'sd8192, 8191, -8192, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{28'sd5, -28'sd5, 14'sd0, 8191, -8192, 1'b1, 1'b1, 1'b1};
    vecs[7] = '{28'sd0, 28'sd0, 14'sd0, 0, 0, 1'b1, 1'b1, 1'b0};
    vecs[8] = '{-28'sd40960, 28'sd40955, 14'sd5, -8192, 8191, 1'b0, 1'b0, 1'b1};
    vecs[9] = '{-28'sd300, 28'sd45, 14'sd15, -20, 3, 1'b0, 1'b0, 1'b1};

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    cr = '0;
    ci = '0;
    br = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ar", ar, 0);
    check("reset_ai", ai, 0);
    check("reset_sat", sat, 0);
    check("reset_div_zero", div_zero, 0);
    check("reset_out_valid", out_valid, 0);
    rst = 1'b0;
    #1;
    check("in_ready_after_reset", in_ready, 1);
    @(posedge clk);
    #1;

    // Table-driven single operations
    for (int v = 0; v < 10; v++) begin
      start_op(vecs[v].cr, vecs[v].ci, vecs[v].br);
      wait_done(lat, ready_hi);
      check("latency", lat, 29);
      check("in_ready_low_while_busy", ready_hi, 0);
      check("in_ready_low_in_done", in_ready, 0);
      check("ar", ar, vecs[v].ar);
      check("ai", ai, vecs[v].ai);
      if (vecs[v].chk_sat) check("sat", sat, vecs[v].sat);
      check("div_zero", div_zero, vecs[v].dz);
      $display("[TB] vec %0d cr=%0d ci=%0d br=%0d -> ar=%0d ai=%0d sat=%0d dz=%0d lat=%0d",
               v, vecs[v].cr, vecs[v].ci, vecs[v].br, ar, ai, sat, div_zero, lat);
      pop_result();
    end

    // Backpressure: hold the result, offer a new operation that must wait
    start_op(28'sd1000, -28'sd1000, -14'sd7);
    wait_done(lat, ready_hi);
    check("bp_latency", lat, 29);
    cr = 28'sd81;
    ci = -28'sd81;
    br = 14'sd9;
    in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      check("bp_out_valid_held", out_valid, 1);
      check("bp_in_ready_low", in_ready, 0);
      check("bp_ar_held", ar, -142);
      check("bp_ai_held", ai, 142);
    end
    $display("[TB] backpressure first ar=%0d ai=%0d held 6 cycles", ar, ai);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp_idle_out_valid", out_valid, 0);
    check("bp_idle_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_done(lat, ready_hi);
    check("bp2_latency", lat, 29);
    check("bp2_in_ready_low", ready_hi, 0);
    check("bp2_ar", ar, 9);
    check("bp2_ai", ai, -9);
    $display("[TB] back-to-back second ar=%0d ai=%0d lat=%0d", ar, ai, lat);
    pop_result();

    // Reset while counter = 10 in CALC
    start_op(28'sd5000, -28'sd5000, 14'sd3);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_ar", ar, 0);
    check("midrst_ai", ai, 0);
    check("midrst_sat", sat, 0);
    check("midrst_div_zero", div_zero, 0);
    check("midrst_out_valid", out_valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 1);
    seen_valid = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen_valid++;
    end
    check("midrst_no_out_valid", seen_valid, 0);
    $display("[TB] mid-operation reset, out_valid pulses afterwards=%0d", seen_valid);

    start_op(-28'sd300, 28'sd45, 14'sd15);
    wait_done(lat, ready_hi);
    check("post_rst_latency", lat, 29);
    check("post_rst_ar", ar, -20);
    check("post_rst_ai", ai, 3);
    $display("[TB] after reset ar=%0d ai=%0d lat=%0d", ar, ai, lat);
    pop_result();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
